// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU opcodes, widths,
// the command record carried through the FIFO and the issue FSM encoding.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [OP_W-1:0] OP_DIV = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR = 4'h9;
  localparam logic [OP_W-1:0] OP_ROL = 4'hA;
  localparam logic [OP_W-1:0] OP_ROR = 4'hB;
  localparam logic [OP_W-1:0] OP_INC = 4'hC;
  localparam logic [OP_W-1:0] OP_DEC = 4'hD;
  localparam logic [OP_W-1:0] OP_LT  = 4'hE;
  localparam logic [OP_W-1:0] OP_EQ  = 4'hF;

  // One queued command: 4 + 8 + 8 = 20 bits.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and result-side signals of the sequencer.
// slave is the sequencer's view, master is the surrounding system's view.
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 3
);
  import alu_pkg::*;

  logic              flush;
  logic              busy;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_div0;
  logic [TAG_W-1:0]  res_tag;

  modport slave (
    input  flush, cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_carry, res_ready,
    output busy, cmd_ready, alu_op, alu_a, alu_b,
           res_valid, res_data, res_carry, res_div0, res_tag
  );

  modport master (
    output flush, cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_carry, res_ready,
    input  busy, cmd_ready, alu_op, alu_a, alu_b,
           res_valid, res_data, res_carry, res_div0, res_tag
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of cmd_t, synchronous write, head read straight
// from the storage registers, flush empties it in one cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage write; contents are only meaningful between the pointers.
  // NOTE: the storage array has no reset -- count/pointers define validity, so clearing data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  // NOTE: state is assigned with <= so every register samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the external 8-bit combinational ALU: queues commands,
// drives one at a time onto registered operand lines, captures the result a
// cycle later and hands it downstream with a sequence tag and div-by-zero flag.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);

  state_t            state;
  cmd_t              head;
  logic              full;
  logic              empty;
  logic              pop;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_carry_q;
  logic              res_div0_q;
  logic [TAG_W-1:0]  tag_q;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (bus.cmd_valid),
    .din   ('{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // The head leaves the FIFO whenever the FSM is free to take a new command.
  // NOTE: always_comb assigns a default first so no path can leave pop unassigned and infer a latch.
  always_comb begin
    pop = 1'b0;
    if (!bus.flush && !empty) begin
      pop = (state == IDLE) || (state == HOLD && bus.res_ready);
    end
  end

  // Issue FSM with operand, result and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_div0_q  <= 1'b0;
      tag_q       <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            op_q  <= head.op;
            a_q   <= head.a;
            b_q   <= head.b;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= bus.alu_result;
          res_carry_q <= bus.alu_carry;
          res_div0_q  <= (op_q == OP_DIV) && (b_q == '0);
          res_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            tag_q       <= tag_q + TAG_W'(1);
            if (!empty) begin
              op_q  <= head.op;
              a_q   <= head.a;
              b_q   <= head.b;
              state <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.busy      = !empty || (state != IDLE);
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_div0  = res_div0_q;
  assign bus.res_tag   = tag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a reference ALU sits on the alu_* lines,
// directed commands push hand-computed results into a scoreboard queue, and
// a monitor pops and compares on every result handshake.
// The reference ALU reports the low-nibble (half) carry for ADD and the
// borrow for SUB; DIV by zero returns 8'hFF.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       div0;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_cmd_sequencer_if #(.TAG_W(3)) bus ();

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;
  logic [2:0] mon_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  logic [4:0] nib_sum;
  always_comb begin
    bus.alu_result = 8'h00;
    bus.alu_carry  = 1'b0;
    nib_sum        = {1'b0, bus.alu_a[3:0]} + {1'b0, bus.alu_b[3:0]};
    case (bus.alu_op)
      OP_ADD: begin
        bus.alu_result = bus.alu_a + bus.alu_b;
        bus.alu_carry  = nib_sum[4];
      end
      OP_SUB: begin
        bus.alu_result = bus.alu_a - bus.alu_b;
        bus.alu_carry  = bus.alu_a < bus.alu_b;
      end
      OP_DIV:  bus.alu_result = (bus.alu_b == 8'h00) ? 8'hFF : bus.alu_a / bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compares every accepted result, in order.
  initial begin
    exp_t e;
    mon_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_tag = '0;
      end else if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {24'h0, bus.res_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("res_data",  {24'h0, bus.res_data},  {24'h0, e.data});
          check("res_carry", {31'h0, bus.res_carry}, {31'h0, e.carry});
          check("res_div0",  {31'h0, bus.res_div0},  {31'h0, e.div0});
          check("res_tag",   {29'h0, bus.res_tag},   {29'h0, mon_tag});
          mon_tag = mon_tag + 3'd1;
        end
      end
    end
  end

  // Present one command, wait for acceptance, queue its expected result.
  // Called and returns just after a rising edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] data, input logic carry, input logic div0);
    exp_t e;
    logic acc;
    int   budget;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    budget        = 50;
    do begin
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!acc && budget > 0);
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      check("send_timeout", 32'h0, 32'h1);
    end else begin
      e.data  = data;
      e.carry = carry;
      e.div0  = div0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.res_ready = 1'b0;

    // Reset state
    #3;
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    check("rst_busy",      {31'h0, bus.busy},      32'h0);
    check("rst_alu_op",    {28'h0, bus.alu_op},    32'h0);
    check("rst_res_tag",   {29'h0, bus.res_tag},   32'h0);
    do_reset();

    // Single command latency: accept E0, operands E1, result after E2
    bus.res_ready = 1'b1;
    send(OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_valid_e0", {31'h0, bus.res_valid}, 32'h0);
    @(negedge clk);
    check("lat_valid_e1", {31'h0, bus.res_valid}, 32'h0);
    check("lat_alu_a",    {24'h0, bus.alu_a},     32'h0F);
    @(negedge clk);
    check("lat_valid_e2", {31'h0, bus.res_valid}, 32'h1);
    wait_drain(20);

    // Burst with consumer stalled: one command held, four fill the FIFO
    do_reset();
    bus.res_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    send(OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b1, 1'b0);
    send(OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    send(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    check("burst_ready_before_full", {31'h0, bus.cmd_ready}, 32'h1);
    send(OP_XOR, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0);
    check("burst_full", {31'h0, bus.cmd_ready}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("burst_still_full", {31'h0, bus.cmd_ready}, 32'h0);
    check("burst_held_valid", {31'h0, bus.res_valid}, 32'h1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("burst_full_before_pop", {31'h0, bus.cmd_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("burst_ready_after_pop", {31'h0, bus.cmd_ready}, 32'h1);
    wait_drain(40);

    // Divide-by-zero flag
    do_reset();
    bus.res_ready = 1'b1;
    send(OP_DIV, 8'h20, 8'h00, 8'hFF, 1'b0, 1'b1);
    send(OP_DIV, 8'h20, 8'h04, 8'h08, 1'b0, 1'b0);
    wait_drain(20);

    // Flush in HOLD with two queued; the push offered with the flush is dropped
    do_reset();
    bus.res_ready = 1'b0;
    send(OP_ADD, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send(OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send(OP_ADD, 8'h04, 8'h05, 8'h09, 1'b0, 1'b0);
    check("flush_pre_valid", {31'h0, bus.res_valid}, 32'h1);
    check("flush_pre_busy",  {31'h0, bus.busy},      32'h1);
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 8'h77;
    bus.cmd_b     = 8'h01;
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    check("flush_valid", {31'h0, bus.res_valid}, 32'h0);
    check("flush_busy",  {31'h0, bus.busy},      32'h0);
    check("flush_tag",   {29'h0, bus.res_tag},   32'h0);
    check("flush_alu_a", {24'h0, bus.alu_a},     32'h11);
    bus.res_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("flush_quiet_busy", {31'h0, bus.busy}, 32'h0);

    // Asynchronous reset in the middle of EXEC
    do_reset();
    bus.res_ready = 1'b1;
    send(OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0);
    send(OP_ADD, 8'h08, 8'h08, 8'h10, 1'b1, 1'b0);
    wait_drain(20);
    check("pre_reset_tag", {29'h0, bus.res_tag}, 32'h2);
    send(OP_XOR, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("arst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    check("arst_res_data",  {24'h0, bus.res_data},  32'h0);
    check("arst_res_tag",   {29'h0, bus.res_tag},   32'h0);
    check("arst_alu_a",     {24'h0, bus.alu_a},     32'h0);
    check("arst_alu_b",     {24'h0, bus.alu_b},     32'h0);
    check("arst_busy",      {31'h0, bus.busy},      32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_AND, 8'h0F, 8'hFC, 8'h0C, 1'b0, 1'b0);
    wait_drain(20);

    // Nine back-to-back results: tag wraps 7 -> 0; operands hold in IDLE
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(OP_ADD, 8'(i), 8'h10, 8'(i + 16), 1'b0, 1'b0);
    end
    wait_drain(60);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_tag",   {29'h0, bus.res_tag}, 32'h1);
    check("idle_alu_a", {24'h0, bus.alu_a},   32'h08);
    check("idle_alu_b", {24'h0, bus.alu_b},   32'h10);
    check("idle_busy",  {31'h0, bus.busy},    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
